// File: rtl/soc_pkg.sv
// Shared SoC definitions: datapath widths, the opcodes decode already relies on,
// and the prefetch queue entry layout.
package soc_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned ILEN_BYTES = 4;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } pf_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head output that holds its last value
// while empty, plus flush and occupancy count.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           rdata,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             wr_en, rd_en;

  always_comb begin
    wr_en   = push && !flush;
    rd_en   = pop && (count_q != '0);
    count_d = count_q + CW'(wr_en) - CW'(rd_en);
    head_d  = head_q;
    // The head register always mirrors the oldest entry so outputs never see mem muxing.
    if (rd_en) begin
      if (count_q > CW'(1)) head_d = mem[rd_ptr_q + AW'(1)];
      else if (wr_en)       head_d = wdata;
    end else if (count_q == '0 && wr_en) begin
      head_d = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wdata;
  end

  assign rdata = head_q;
  assign valid = (count_q != '0);
  assign count = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !flush && !rd_en && count_q == CW'(DEPTH)));

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetch queue: runs sequential ROM fetches ahead of decode and
// flushes / drops stale responses on a control-flow redirect.
module instr_prefetch import soc_pkg::*; #(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               mem_req,
  output logic [XLEN-1:0]    mem_addr,
  input  logic               mem_rvalid,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [XLEN-1:0]    out_pc,
  input  logic               redirect,
  input  logic [XLEN-1:0]    redirect_pc
);

  localparam int unsigned CW     = $clog2(DEPTH+1);
  localparam logic [CW:0] DepthW = (CW+1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   count;
  logic [CW:0]     inflight;
  logic            resp_drop, push, pop, fifo_valid;
  pf_entry_t       wentry, rentry;

  always_comb begin
    inflight  = (CW+1)'(count) + (CW+1)'(outstanding_q);
    mem_req   = !reset && !redirect && (inflight < DepthW);
    mem_addr  = fetch_pc_q;
    resp_drop = mem_rvalid && (drop_q != '0);
    push      = mem_rvalid && !resp_drop && !redirect;
    pop       = fifo_valid && out_ready;
    wentry    = '{pc: resp_pc_q, instr: mem_rdata};

    outstanding_d = outstanding_q + CW'(mem_req) - CW'(mem_rvalid);
    // A response arriving in the redirect cycle is no longer in flight, so it is
    // not counted again; every other outstanding response is stale.
    drop_d = redirect ? (outstanding_q - CW'(mem_rvalid)) : (drop_q - CW'(resp_drop));

    fetch_pc_d = fetch_pc_q;
    if (redirect)     fetch_pc_d = align_pc(redirect_pc);
    else if (mem_req) fetch_pc_d = fetch_pc_q + XLEN'(ILEN_BYTES);

    // Surviving responses are sequential from the last redirect, so their PC is tracked here.
    resp_pc_d = resp_pc_q;
    if (redirect)  resp_pc_d = align_pc(redirect_pc);
    else if (push) resp_pc_d = resp_pc_q + XLEN'(ILEN_BYTES);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  sync_fifo #(
    .WIDTH($bits(pf_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .wdata(wentry),
    .pop  (pop),
    .flush(redirect),
    .rdata(rentry),
    .valid(fifo_valid),
    .count(count)
  );

  assign out_valid = fifo_valid;
  assign out_instr = rentry.instr;
  assign out_pc    = rentry.pc;

  a_inflight: assert property (@(posedge clk) disable iff (reset) inflight <= DepthW);
  a_drop:     assert property (@(posedge clk) disable iff (reset) drop_q <= outstanding_q);

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch with a fixed-latency ROM model.
module tb_instr_prefetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_rvalid, out_valid;
  logic        out_ready = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] mem_addr, mem_rdata, out_instr, out_pc;
  logic [31:0] redirect_pc = 32'h0;

  int total = 0;
  int bad   = 0;
  int issued;

  // ROM model: response arrives lat_m1+1 cycles after the request.
  logic [2:0]  lat_m1 = 3'd0;
  logic [7:0]  pv = 8'h00;
  logic [31:0] pa [8];

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h00300293;
      32'h4:   return 32'h00428293;
      default: return 32'hA500_0000 ^ a;
    endcase
  endfunction

  always @(posedge clk) begin
    pv    <= {pv[6:0], mem_req};
    pa[0] <= mem_addr;
    for (int i = 1; i < 8; i++) pa[i] <= pa[i-1];
  end

  assign mem_rvalid = pv[lat_m1];
  assign mem_rdata  = mem_rvalid ? rom_word(pa[lat_m1]) : 32'hDEAD_BEEF;

  instr_prefetch #(
    .DEPTH(4),
    .RESET_PC(32'h0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .redirect   (redirect),
    .redirect_pc(redirect_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  // Hold reset for n cycles starting with the current one; returns at cycle 0.
  task automatic rst(input int n);
    reset    = 1'b1;
    redirect = 1'b0;
    repeat (n) nxt();
    reset = 1'b0;
  endtask

  initial begin
    // Reset values and first-fetch latency.
    nxt(); #1;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    nxt(); reset = 1'b0; #1;
    chk("c0_req", 32'(mem_req), 32'd1);
    chk("c0_addr", mem_addr, 32'h0);
    nxt(); #1;
    chk("c1_addr", mem_addr, 32'h4);
    chk("c1_valid", 32'(out_valid), 32'd0);
    nxt(); #1;
    chk("c2_valid", 32'(out_valid), 32'd1);
    chk("c2_instr", out_instr, 32'h00300293);
    chk("c2_pc", out_pc, 32'h0);
    nxt(); #1;
    chk("c3_instr", out_instr, 32'h00428293);
    chk("c3_pc", out_pc, 32'h4);
    nxt(); #1;
    chk("c4_valid", 32'(out_valid), 32'd1);
    chk("c4_pc", out_pc, 32'h8);

    // Backpressure: exactly DEPTH requests, then an in-order gapless drain.
    nxt(); reset = 1'b1; out_ready = 1'b0; #1;
    chk("rst2_req", 32'(mem_req), 32'd0);
    nxt(); reset = 1'b0;
    issued = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) nxt();
      #1;
      if (mem_req) begin
        chk("stall_addr", mem_addr, 32'(issued * 4));
        issued++;
      end
    end
    chk("stall_issued", 32'(issued), 32'd4);
    chk("stall_req_off", 32'(mem_req), 32'd0);
    nxt(); out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      chk("drain_valid", 32'(out_valid), 32'd1);
      chk("drain_pc", out_pc, 32'(j * 4));
      chk("drain_instr", out_instr, rom_word(32'(j * 4)));
      nxt();
    end

    // Latency-3 ROM: redirect with responses outstanding drops the stale ones.
    lat_m1 = 3'd2;
    rst(4);
    #1;
    chk("l3_c0_addr", mem_addr, 32'h0);
    nxt(); nxt(); nxt();
    redirect = 1'b1; redirect_pc = 32'h40; #1;
    chk("l3_redir_req", 32'(mem_req), 32'd0);
    nxt(); redirect = 1'b0; #1;
    chk("l3_new_req", 32'(mem_req), 32'd1);
    chk("l3_new_addr", mem_addr, 32'h40);
    chk("l3_drop_valid", 32'(out_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      nxt(); #1;
      chk("l3_drop_valid", 32'(out_valid), 32'd0);
    end
    nxt(); #1;
    chk("l3_head_valid", 32'(out_valid), 32'd1);
    chk("l3_head_pc", out_pc, 32'h40);
    chk("l3_head_instr", out_instr, 32'hA500_0040);
    nxt(); #1;
    chk("l3_next_pc", out_pc, 32'h44);

    // Redirect to an unaligned PC in the same cycle as a transfer.
    lat_m1 = 3'd0;
    rst(4);
    nxt(); nxt(); #1;
    chk("rd_c2_pc", out_pc, 32'h0);
    nxt(); redirect = 1'b1; redirect_pc = 32'h23; #1;
    chk("rd_xfer_valid", 32'(out_valid), 32'd1);
    chk("rd_xfer_pc", out_pc, 32'h4);
    chk("rd_xfer_req", 32'(mem_req), 32'd0);
    nxt(); redirect = 1'b0; #1;
    chk("rd_new_req", 32'(mem_req), 32'd1);
    chk("rd_new_addr", mem_addr, 32'h20);
    chk("rd_flushed", 32'(out_valid), 32'd0);
    nxt(); #1;
    chk("rd_gap", 32'(out_valid), 32'd0);
    chk("rd_addr2", mem_addr, 32'h24);
    nxt(); #1;
    chk("rd_head_valid", 32'(out_valid), 32'd1);
    chk("rd_head_pc", out_pc, 32'h20);
    chk("rd_head_instr", out_instr, 32'hA500_0020);

    // Fetch PC wrap through the top of the address space.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    nxt(); redirect = 1'b0; #1;
    chk("wr_addr0", mem_addr, 32'hFFFF_FFFC);
    chk("wr_valid0", 32'(out_valid), 32'd0);
    nxt(); #1;
    chk("wr_addr1", mem_addr, 32'h0);
    chk("wr_valid1", 32'(out_valid), 32'd0);
    nxt(); #1;
    chk("wr_pc0", out_pc, 32'hFFFF_FFFC);
    chk("wr_instr0", out_instr, 32'h5AFF_FFFC);
    nxt(); #1;
    chk("wr_pc1", out_pc, 32'h0);
    chk("wr_instr1", out_instr, 32'h00300293);

    // Reset mid-stream with a response landing in the reset cycle.
    nxt(); reset = 1'b1; #1;
    chk("mr_req", 32'(mem_req), 32'd0);
    nxt(); reset = 1'b0; #1;
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_pc", out_pc, 32'h0);
    chk("mr_instr", out_instr, 32'h0);
    chk("mr_restart_req", 32'(mem_req), 32'd1);
    chk("mr_restart_addr", mem_addr, 32'h0);
    nxt(); #1;
    chk("mr_valid1", 32'(out_valid), 32'd0);
    nxt(); #1;
    chk("mr_head_valid", 32'(out_valid), 32'd1);
    chk("mr_head_pc", out_pc, 32'h0);
    chk("mr_head_instr", out_instr, 32'h00300293);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
